// File: rtl/instruction_loader_pkg.sv
// -----------------------------------------------------------------------------
// instruction_loader_pkg
//   Shared definitions for the boot-time program loader: FSM state encodings,
//   stream byte width, the order of fields in a program image frame, and the
//   checksum accumulation helper.
// -----------------------------------------------------------------------------
package instruction_loader_pkg;

    localparam int BYTE_W = 8;

    // Loader FSM states. The contiguous range LEN_HI..CHECK is the "loading"
    // window; the output decode relies on that ordering.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN_HI  = 3'd1;
    localparam logic [2:0] ST_LEN_LO  = 3'd2;
    localparam logic [2:0] ST_DATA_HI = 3'd3;
    localparam logic [2:0] ST_DATA_LO = 3'd4;
    localparam logic [2:0] ST_CHECK   = 3'd5;
    localparam logic [2:0] ST_RUN     = 3'd6;
    localparam logic [2:0] ST_ERROR   = 3'd7;

    // Order of fields in an image frame as they arrive on the byte stream:
    // length (big-endian), N words (big-endian), then the payload checksum.
    typedef enum logic [2:0] {
        FIELD_LEN_HI  = 3'd0,
        FIELD_LEN_LO  = 3'd1,
        FIELD_DATA_HI = 3'd2,
        FIELD_DATA_LO = 3'd3,
        FIELD_CKSUM   = 3'd4
    } frameField_e;

    // Mod-256 running sum of payload bytes; length bytes never pass through here.
    function automatic logic [BYTE_W-1:0] cksumAdd(input logic [BYTE_W-1:0] acc,
                                                   input logic [BYTE_W-1:0] dataByte);
        return acc + dataByte;
    endfunction

    // True for the states in which an image is being received.
    function automatic logic isLoading(input logic [2:0] st);
        return (st >= ST_LEN_HI) && (st <= ST_CHECK);
    endfunction

endpackage

// File: rtl/instruction_ram.sv
// -----------------------------------------------------------------------------
// instruction_ram
//   DEPTH x WORD_W instruction store, one synchronous write port and one
//   asynchronous read port. Contents are never cleared; they survive reset.
// Ports:
//   clk     in  clock for the write port
//   wrEn    in  write enable
//   wrAddr  in  write address
//   wrData  in  write data
//   rdAddr  in  read address
//   rdData  out read data (combinational from rdAddr)
// -----------------------------------------------------------------------------
module instruction_ram #(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [WORD_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [WORD_W-1:0] rdData
);

    logic [WORD_W-1:0] mem_r [0:(1 << ADDR_W)-1];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_r[wrAddr] <= wrData;
        end
    end

    assign rdData = mem_r[rdAddr];

endmodule

// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//   Boot-time program loader and instruction store for the Hack CPU. Receives a
//   framed image (LEN_HI, LEN_LO, N x {HI, LO}, CKSUM) over a byte stream,
//   writes it into the instruction RAM, holds the CPU in reset while loading,
//   and serves instruct = RAM[pc] once a valid image is running.
// Ports:
//   clk        in  clock
//   reset      in  synchronous active-low reset
//   load_req   in  start loading an image (ignored while busy)
//   rx_data    in  image byte
//   rx_valid   in  rx_data valid
//   rx_ready   out loader accepts a byte this cycle
//   pc         in  CPU program counter (bits at and above ADDR_W ignored)
//   instruct   out instruction to the CPU, zero unless running
//   cpu_reset  out active-high CPU reset, low only while running
//   busy       out load in progress
//   done       out valid image loaded, CPU running
//   err        out last load failed
// -----------------------------------------------------------------------------
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [15:0]       pc,
    output logic [WORD_W-1:0] instruct,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [2:0]        state_r;
    logic [2:0]        stateNext_s;
    logic [ADDR_W:0]   wrAddr_r;      // one extra bit so N == DEPTH ends without wrapping
    logic [ADDR_W:0]   len_r;
    logic [7:0]        lenHi_r;
    logic [7:0]        hiByte_r;
    logic [7:0]        sum_r;
    logic              rxReady_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              cpuReset_r;

    logic              accept_s;
    logic [15:0]       lenFull_s;
    logic              lenTooBig_s;
    logic              lenZero_s;
    logic [ADDR_W:0]   wrAddrInc_s;
    logic              ramWe_s;
    logic [WORD_W-1:0] ramRdData_s;
    logic              unusedPcHi_s;

    assign accept_s    = rx_valid & rxReady_r;
    assign lenFull_s   = {lenHi_r, rx_data};
    assign lenTooBig_s = (32'(lenFull_s) > 32'(DEPTH));
    assign lenZero_s   = (lenFull_s == 16'h0000);
    assign wrAddrInc_s = wrAddr_r + (ADDR_W+1)'(1);
    assign ramWe_s     = (state_r == ST_DATA_LO) & accept_s;
    assign unusedPcHi_s = ^pc[15:ADDR_W];

    // Next-state decode for the frame parser.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (load_req) begin
                    stateNext_s = ST_LEN_HI;
                end else begin
                    stateNext_s = state_r;
                end
            end
            ST_LEN_HI: begin
                if (accept_s) begin
                    stateNext_s = ST_LEN_LO;
                end else begin
                    stateNext_s = state_r;
                end
            end
            ST_LEN_LO: begin
                if (!accept_s) begin
                    stateNext_s = state_r;
                end else if (lenTooBig_s) begin
                    stateNext_s = ST_ERROR;
                end else if (lenZero_s) begin
                    stateNext_s = ST_CHECK;
                end else begin
                    stateNext_s = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (accept_s) begin
                    stateNext_s = ST_DATA_LO;
                end else begin
                    stateNext_s = state_r;
                end
            end
            ST_DATA_LO: begin
                if (!accept_s) begin
                    stateNext_s = state_r;
                end else if (wrAddrInc_s == len_r) begin
                    stateNext_s = ST_CHECK;
                end else begin
                    stateNext_s = ST_DATA_HI;
                end
            end
            ST_CHECK: begin
                if (!accept_s) begin
                    stateNext_s = state_r;
                end else if (rx_data == sum_r) begin
                    stateNext_s = ST_RUN;
                end else begin
                    stateNext_s = ST_ERROR;
                end
            end
            default: begin
                stateNext_s = ST_IDLE;
            end
        endcase
    end

    // State register and load datapath: length, write address, high byte, checksum.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            wrAddr_r <= '0;
            len_r    <= '0;
            lenHi_r  <= 8'h00;
            hiByte_r <= 8'h00;
            sum_r    <= 8'h00;
        end else begin
            state_r <= stateNext_s;
            case (state_r)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (load_req) begin
                        wrAddr_r <= '0;
                        sum_r    <= 8'h00;
                    end
                end
                ST_LEN_HI: begin
                    if (accept_s) begin
                        lenHi_r <= rx_data;
                    end
                end
                ST_LEN_LO: begin
                    // Only kept when in range, so the truncation never loses bits.
                    if (accept_s) begin
                        len_r <= lenFull_s[ADDR_W:0];
                    end
                end
                ST_DATA_HI: begin
                    if (accept_s) begin
                        hiByte_r <= rx_data;
                        sum_r    <= cksumAdd(sum_r, rx_data);
                    end
                end
                ST_DATA_LO: begin
                    if (accept_s) begin
                        wrAddr_r <= wrAddrInc_s;
                        sum_r    <= cksumAdd(sum_r, rx_data);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs registered from the next state so they track state_r exactly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxReady_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            cpuReset_r <= 1'b1;
        end else begin
            rxReady_r  <= isLoading(stateNext_s);
            busy_r     <= isLoading(stateNext_s);
            done_r     <= (stateNext_s == ST_RUN);
            err_r      <= (stateNext_s == ST_ERROR);
            cpuReset_r <= (stateNext_s != ST_RUN);
        end
    end

    instruction_ram #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk    (clk),
        .wrEn   (ramWe_s),
        .wrAddr (wrAddr_r[ADDR_W-1:0]),
        .wrData ({hiByte_r, rx_data}),
        .rdAddr (pc[ADDR_W-1:0]),
        .rdData (ramRdData_s)
    );

    assign rx_ready  = rxReady_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign cpu_reset = cpuReset_r;
    assign instruct  = (state_r == ST_RUN) ? ramRdData_s : {WORD_W{1'b0}};

endmodule

// File: tb/tb_instruction_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_loader
//   Directed self-checking bench for instruction_loader: reset values, a good
//   image, bad checksum, oversize and zero length, stream gaps with an ignored
//   load_req, reset mid-load and reload from RUN.
// -----------------------------------------------------------------------------
module tb_instruction_loader;

    logic        clk;
    logic        reset;
    logic        load_req;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] pc;
    logic [15:0] instruct;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err;

    int errCount;
    int checkCount;

    instruction_loader dut (
        .clk       (clk),
        .reset     (reset),
        .load_req  (load_req),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .pc        (pc),
        .instruct  (instruct),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkEq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic sendByte(input logic [7:0] b, input int gap);
        int waitCnt;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        waitCnt  = 0;
        while (!rx_ready && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!rx_ready) begin
            checkEq("rxReadyTimeout", 16'(rx_ready), 16'h0001);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    // One-cycle load_req pulse; returns just after the edge that samples it.
    task automatic pulseLoad();
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic readPc(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        pc = addr;
        #1;
        checkEq(tag, instruct, exp);
    endtask

    initial begin
        logic [7:0] goodImg [0:6];
        errCount   = 0;
        checkCount = 0;
        reset      = 1'b0;
        load_req   = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        pc         = 16'h0000;
        goodImg    = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};

        // Test 1: reset values
        @(posedge clk);
        #1;
        checkEq("rstCpuReset", 16'(cpu_reset), 16'h0001);
        checkEq("rstRxReady",  16'(rx_ready),  16'h0000);
        checkEq("rstBusy",     16'(busy),      16'h0000);
        checkEq("rstDone",     16'(done),      16'h0000);
        checkEq("rstErr",      16'(err),       16'h0000);
        checkEq("rstInstruct", instruct,       16'h0000);
        @(negedge clk);
        reset = 1'b1;

        // Test 2: good two-word image
        pulseLoad();
        checkEq("t2BusyAfterReq", 16'(busy), 16'h0001);
        for (int i = 0; i < 6; i++) sendByte(goodImg[i], 0);
        checkEq("t2DoneBeforeCk", 16'(done), 16'h0000);
        checkEq("t2CpuRstBeforeCk", 16'(cpu_reset), 16'h0001);
        sendByte(goodImg[6], 0);
        checkEq("t2Done",     16'(done),      16'h0001);
        checkEq("t2CpuReset", 16'(cpu_reset), 16'h0000);
        checkEq("t2Busy",     16'(busy),      16'h0000);
        checkEq("t2RxReady",  16'(rx_ready),  16'h0000);
        readPc("t2Pc0",    16'h0000, 16'h1234);
        readPc("t2Pc1",    16'h0001, 16'hABCD);
        readPc("t2Pc8001", 16'h8001, 16'hABCD);

        // Test 3: bad checksum, then a fresh one-word image 55AA (sum FF)
        pulseLoad();
        for (int i = 0; i < 6; i++) sendByte(goodImg[i], 0);
        sendByte(8'hBF, 0);
        checkEq("t3Err",      16'(err),       16'h0001);
        checkEq("t3CpuReset", 16'(cpu_reset), 16'h0001);
        checkEq("t3Done",     16'(done),      16'h0000);
        readPc("t3Instruct", 16'h0000, 16'h0000);
        pulseLoad();
        sendByte(8'h00, 0);
        sendByte(8'h01, 0);
        sendByte(8'h55, 0);
        sendByte(8'hAA, 0);
        sendByte(8'hFF, 0);
        checkEq("t3ReloadDone", 16'(done), 16'h0001);
        checkEq("t3ReloadErr",  16'(err),  16'h0000);
        readPc("t3Pc0", 16'h0000, 16'h55AA);
        readPc("t3Pc1KeepsOld", 16'h0001, 16'hABCD);

        // Test 4: oversize length, then zero-length image
        pulseLoad();
        sendByte(8'h80, 0);
        sendByte(8'h01, 0);
        checkEq("t4Err",     16'(err),      16'h0001);
        checkEq("t4RxReady", 16'(rx_ready), 16'h0000);
        checkEq("t4Busy",    16'(busy),     16'h0000);
        pulseLoad();
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        checkEq("t4ZeroBusy", 16'(busy), 16'h0001);
        sendByte(8'h00, 0);
        checkEq("t4ZeroDone", 16'(done), 16'h0001);
        readPc("t4Pc0", 16'h0000, 16'h55AA);
        readPc("t4Pc1", 16'h0001, 16'hABCD);

        // Test 5: gaps on the stream, load_req while busy is ignored
        pulseLoad();
        for (int i = 0; i < 7; i++) begin
            sendByte(goodImg[i], int'($urandom_range(0, 3)));
            if (i == 3) begin
                pulseLoad();
                checkEq("t5BusyAfterIgnoredReq", 16'(busy), 16'h0001);
            end
        end
        checkEq("t5Done", 16'(done), 16'h0001);
        checkEq("t5Err",  16'(err),  16'h0000);
        readPc("t5Pc0", 16'h0000, 16'h1234);
        readPc("t5Pc1", 16'h0001, 16'hABCD);

        // Test 6: reset while waiting for a low byte, then reload from RUN
        pulseLoad();
        sendByte(8'h00, 0);
        sendByte(8'h02, 0);
        sendByte(8'h77, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkEq("t6RstBusy",     16'(busy),      16'h0000);
        checkEq("t6RstRxReady",  16'(rx_ready),  16'h0000);
        checkEq("t6RstCpuReset", 16'(cpu_reset), 16'h0001);
        checkEq("t6RstDone",     16'(done),      16'h0000);
        @(negedge clk);
        reset = 1'b1;
        pulseLoad();
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        checkEq("t6RunDone", 16'(done), 16'h0001);
        readPc("t6Pc0Intact", 16'h0000, 16'h1234);
        pulseLoad();
        checkEq("t6ReloadCpuReset", 16'(cpu_reset), 16'h0001);
        checkEq("t6ReloadBusy",     16'(busy),      16'h0001);
        checkEq("t6ReloadDone",     16'(done),      16'h0000);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
